instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Instruction-fetch stage between the program-counter register and decode.
//  Accepts a PC over a valid/ready handshake and issues a request to instruction
//  memory (variable latency, req/ack). Holds the returned word with its PC until
//  decode takes it. Back-pressures the PC update path through pc_ready.
// PARAMETERS
//  ADDR_W     32             PC / memory address width
//  DATA_W     32             instruction word width
//  NOP_INSTR  32'h0000_0000  word driven on if_instr for misaligned PCs
//  TIMEOUT    255            max WAIT cycles before bus-error; 8-bit counter
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  pc_in       in   ADDR_W  PC from PC register
//  pc_valid    in   1       pc_in is valid
//  pc_ready    out  1       fetch accepts pc_in this cycle (PC may advance)
//  flush       in   1       branch/jump redirect: discard in-flight/held fetch
//  imem_req    out  1       instruction memory request
//  imem_addr   out  ADDR_W  request address (stable while imem_req=1)
//  imem_ack    in   1       one-cycle response strobe
//  imem_rdata  in   DATA_W  instruction word, valid with imem_ack
//  if_valid    out  1       if_instr/if_pc valid to decode
//  if_ready    in   1       decode accepts
//  if_instr    out  DATA_W  fetched instruction
//  if_pc       out  ADDR_W  PC of if_instr
//  if_err      out  1       with if_valid: misaligned PC or memory timeout
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; drop flag, timeout counter cleared.
//  - pc_ready = !flush && (IDLE || (HOLD && if_ready)); comb.
//    accept = pc_valid && pc_ready.
//  - IDLE: on accept, latch pc_in.
//      If pc_in[1:0]==0, go WAIT; imem_req=1 and imem_addr=pc from next cycle.
//      If misaligned, go HOLD directly with if_instr=NOP_INSTR, if_err=1, no request.
//  - WAIT: imem_req=1; imem_addr held. Counter +1/cycle.
//      imem_ack: capture rdata, if_pc; go HOLD (if_valid=1 next cycle).
//      Counter reaches TIMEOUT with no ack: go HOLD with if_err=1, if_instr=NOP_INSTR.
//  - HOLD: if_valid=1, outputs stable until if_ready.
//      On if_ready: back-to-back accept -> WAIT/HOLD per alignment, else IDLE.
//  - Min latency: PC accept -> if_valid = 2 cycles with a same-cycle ack.
//    Throughput: 1 word per 2 cycles max.
//  - flush priority over accept and if_ready.
//      flush in HOLD: if_valid=0 next cycle, go IDLE.
//      flush in WAIT: request cannot be cancelled. Set drop, keep imem_req until ack
//      or timeout, discard the response, go IDLE; if_valid never asserts for it.
//      flush in IDLE: no effect.
//  - imem_ack outside WAIT: ignored, including a late ack after reset.
//  - Reset mid-WAIT: request dropped immediately; memory must tolerate req falling.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] and
//    perf_wait_cnt[31:0].
//    perf_fetch_cnt: +1 per if_valid&&if_ready handshake.
//    perf_wait_cnt: +1 per cycle in WAIT.
//    Both reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 reset, pc_in=0x0000_0040 valid, ack 1 cycle after req, rdata=0x2008_0005
//     -> if_valid, if_instr=0x2008_0005, if_pc=0x40, if_err=0.
//  T2 if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, pc_ready=0;
//     then if_ready=1 with pc_valid -> next PC accepted same cycle.
//  T3 flush during WAIT, ack 3 cycles later with 0xDEAD_BEEF -> if_valid stays 0,
//     state IDLE after ack.
//  T4 pc_in=0x0000_0042 -> no imem_req, if_valid=1, if_err=1, if_instr=NOP_INSTR.
//  T5 no ack for TIMEOUT cycles -> if_err=1, imem_req deasserts; reset mid-WAIT
//     -> all outputs 0 asynchronously.
//  T6 (FETCH_PERF_CNT_EN) 4 fetches, 3-cycle mem latency
//     -> perf_fetch_cnt=4, perf_wait_cnt=12.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction-fetch stage sitting between the program-counter register and
// decode. A PC is accepted over a valid/ready handshake, a request is issued to
// a variable-latency instruction memory (req/ack), and the returned word is
// held together with its PC until decode takes it.
//
// Ports
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   pc_in/pc_valid    PC offered by the PC register
//   pc_ready          fetch accepts pc_in this cycle (combinational)
//   flush             redirect: discard the in-flight or held fetch
//   imem_req/addr     memory request; address stable while imem_req=1
//   imem_ack/rdata    one-cycle response strobe with instruction word
//   if_valid/ready    handshake towards decode
//   if_instr/if_pc    fetched word and its PC
//   if_err            with if_valid: misaligned PC or memory timeout
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetch_cnt    +1 per if_valid && if_ready handshake
//   perf_wait_cnt     +1 per cycle spent waiting on memory
//   Both reset to zero and wrap at 2^32. Without the macro these ports and
//   counters do not exist; all other behaviour is identical.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Last counter value before giving up: the request is abandoned after
  // exactly TIMEOUT cycles in WAIT without an acknowledge.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e              state_q,    state_d;
  logic                imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   if_pc_q,    if_pc_d;
  logic                if_err_q,   if_err_d;
  logic                drop_q,     drop_d;
  logic [7:0]          tmo_cnt_q,  tmo_cnt_d;

  logic                pc_ready_s;
  logic                accept_s;
  logic                aligned_s;
  logic                tmo_hit_s;

  // Handshake qualifiers towards the PC register and memory timeout detect.
  always_comb begin
    pc_ready_s = !flush &&
                 ((state_q == S_IDLE) || ((state_q == S_HOLD) && if_ready));
    accept_s   = pc_valid && pc_ready_s;
    aligned_s  = (pc_in[1:0] == 2'b00);
    tmo_hit_s  = (state_q == S_WAIT) && !imem_ack && (tmo_cnt_q == TMO_LAST);
  end

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_err_d    = if_err_q;
    drop_d      = drop_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          // Aligned PCs go to memory; misaligned ones are answered locally
          // with an error word and never reach the bus.
          imem_addr_d = pc_in;
          if_pc_d     = pc_in;
          if_instr_d  = NOP_INSTR;
          tmo_cnt_d   = 8'd0;
          drop_d      = 1'b0;
          if (aligned_s) begin
            state_d    = S_WAIT;
            imem_req_d = 1'b1;
            if_valid_d = 1'b0;
            if_err_d   = 1'b0;
          end else begin
            state_d    = S_HOLD;
            imem_req_d = 1'b0;
            if_valid_d = 1'b1;
            if_err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        imem_req_d = 1'b1;
        if (imem_ack) begin
          imem_req_d = 1'b0;
          tmo_cnt_d  = 8'd0;
          drop_d     = 1'b0;
          // A flushed request still has to complete on the bus; its data is
          // simply thrown away.
          if (drop_q || flush) begin
            state_d    = S_IDLE;
            if_valid_d = 1'b0;
            if_err_d   = 1'b0;
          end else begin
            state_d    = S_HOLD;
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = imem_addr_q;
            if_err_d   = 1'b0;
          end
        end else if (tmo_hit_s) begin
          imem_req_d = 1'b0;
          tmo_cnt_d  = 8'd0;
          drop_d     = 1'b0;
          if (drop_q || flush) begin
            state_d    = S_IDLE;
            if_valid_d = 1'b0;
            if_err_d   = 1'b0;
          end else begin
            state_d    = S_HOLD;
            if_valid_d = 1'b1;
            if_instr_d = NOP_INSTR;
            if_pc_d    = imem_addr_q;
            if_err_d   = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (flush) begin
            drop_d = 1'b1;
          end else begin
            drop_d = drop_q;
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          state_d    = S_IDLE;
          if_valid_d = 1'b0;
          if_err_d   = 1'b0;
        end else if (if_ready) begin
          if (accept_s) begin
            // Back-to-back: decode takes the held word while the next PC
            // is launched in the same cycle.
            imem_addr_d = pc_in;
            if_pc_d     = pc_in;
            if_instr_d  = NOP_INSTR;
            tmo_cnt_d   = 8'd0;
            drop_d      = 1'b0;
            if (aligned_s) begin
              state_d    = S_WAIT;
              imem_req_d = 1'b1;
              if_valid_d = 1'b0;
              if_err_d   = 1'b0;
            end else begin
              state_d    = S_HOLD;
              imem_req_d = 1'b0;
              if_valid_d = 1'b1;
              if_err_d   = 1'b1;
            end
          end else begin
            state_d    = S_IDLE;
            if_valid_d = 1'b0;
            if_err_d   = 1'b0;
          end
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d    = S_IDLE;
        imem_req_d = 1'b0;
        if_valid_d = 1'b0;
        if_err_d   = 1'b0;
        drop_d     = 1'b0;
        tmo_cnt_d  = 8'd0;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      if_err_q    <= 1'b0;
      drop_q      <= 1'b0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_err_q    <= if_err_d;
      drop_q      <= drop_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_wait_q;

  // Free-running event counters for delivered words and memory wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= 32'd0;
      perf_wait_q  <= 32'd0;
    end else begin
      if (if_valid_q && if_ready) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end else begin
        perf_fetch_q <= perf_fetch_q;
      end
      if (state_q == S_WAIT) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end else begin
        perf_wait_q <= perf_wait_q;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_wait_cnt  = perf_wait_q;
`else
  // Performance counters are compiled out in this build.
`endif

  assign pc_ready  = pc_ready_s;
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_err    = if_err_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed bench for instr_fetch_stage. Expected decode-side words are pushed
// into a scoreboard when a PC is driven and compared when the stage hands a
// word to decode. A small memory responder acknowledges requests after a
// programmable latency.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 255;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetch_cnt;
  logic [31:0]       perf_wait_cnt;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  // memory responder controls
  logic        mem_en     = 1'b1;
  int          mem_lat    = 0;
  logic        force_en   = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic        stray_ack  = 1'b0;

  instr_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_err     (if_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_0005;
    else return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  // Memory model: answers at the negative edge so the ack is stable at the
  // next rising edge; mem_lat=0 gives a same-cycle acknowledge.
  initial begin
    int lat_cnt;
    lat_cnt    = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
      end else if (mem_en && imem_req && !reset) begin
        if (lat_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = force_en ? force_data : mem_word(imem_addr);
          lat_cnt    = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Decode-side monitor: compares every delivered word against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && if_valid && if_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_if_valid", {32'h0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_instr", 64'(if_instr), 64'(e.instr));
          chk("out_pc",    64'(if_pc),    64'(e.pc));
          chk("out_err",   64'(if_err),   64'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset    = 1'b1;
    pc_in    = 32'h0;
    pc_valid = 1'b0;
    flush    = 1'b0;
    if_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_imem_req",  64'(imem_req),  64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_if_valid",  64'(if_valid),  64'd0);
    chk("rst_if_instr",  64'(if_instr),  64'd0);
    chk("rst_if_pc",     64'(if_pc),     64'd0);
    chk("rst_if_err",    64'(if_err),    64'd0);
    reset = 1'b0;

    // T1: aligned fetch, ack one cycle after the request
    mem_lat  = 1;
    if_ready = 1'b1;
    tick();
    pc_in = 32'h0000_0040; pc_valid = 1'b1;
    #1 chk("t1_pc_ready", 64'(pc_ready), 64'd1);
    sb.push_back('{instr: 32'h2008_0005, pc: 32'h0000_0040, err: 1'b0});
    tick();
    pc_valid = 1'b0;
    chk("t1_req",  64'(imem_req),  64'd1);
    chk("t1_addr", 64'(imem_addr), 64'h40);
    tick();
    chk("t1_not_yet_valid", 64'(if_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(if_valid), 64'd1);
    chk("t1_instr", 64'(if_instr), 64'h2008_0005);
    chk("t1_err",   64'(if_err),   64'd0);
    drain("t1_drain", 10);

    // T2: same-cycle ack (minimum latency), then decode stall for 5 cycles
    mem_lat  = 0;
    if_ready = 1'b0;
    tick();
    pc_in = 32'h0000_0100; pc_valid = 1'b1;
    sb.push_back('{instr: mem_word(32'h100), pc: 32'h0000_0100, err: 1'b0});
    tick();
    pc_valid = 1'b0;
    chk("t2_req",      64'(imem_req),  64'd1);
    chk("t2_addr",     64'(imem_addr), 64'h100);
    chk("t2_valid_c1", 64'(if_valid),  64'd0);
    tick();
    chk("t2_valid_c2", 64'(if_valid),  64'd1);
    chk("t2_req_drop", 64'(imem_req),  64'd0);
    for (int i = 0; i < 5; i++) begin
      pc_in = 32'h0000_0104; pc_valid = 1'b1;
      #1;
      chk("t2_stall_pc_ready", 64'(pc_ready), 64'd0);
      chk("t2_stall_instr",    64'(if_instr), 64'(mem_word(32'h100)));
      chk("t2_stall_pc",       64'(if_pc),    64'h100);
      tick();
    end
    if_ready = 1'b1;
    #1 chk("t2_b2b_pc_ready", 64'(pc_ready), 64'd1);
    sb.push_back('{instr: mem_word(32'h104), pc: 32'h0000_0104, err: 1'b0});
    tick();
    pc_valid = 1'b0;
    chk("t2_b2b_req",   64'(imem_req),  64'd1);
    chk("t2_b2b_addr",  64'(imem_addr), 64'h104);
    chk("t2_b2b_valid", 64'(if_valid),  64'd0);
    drain("t2_drain", 10);

    // T3: flush during WAIT, response arrives 3 cycles later and is dropped
    mem_lat    = 3;
    force_en   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    if_ready   = 1'b1;
    tick();
    pc_in = 32'h0000_0200; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk("t3_req_at_flush",  64'(imem_req), 64'd1);
    chk("t3_flush_pc_rdy",  64'(pc_ready), 64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      flush = 1'b0;
      if (imem_req) n++;
      chk("t3_no_valid", 64'(if_valid), 64'd0);
    end
    chk("t3_req_held_cycles", 64'(n), 64'd3);
    #1 chk("t3_idle_pc_ready", 64'(pc_ready), 64'd1);
    force_en = 1'b0;

    // T4: misaligned PC answered locally with an error word
    if_ready = 1'b0;
    tick();
    pc_in = 32'h0000_0042; pc_valid = 1'b1;
    sb.push_back('{instr: 32'h0000_0000, pc: 32'h0000_0042, err: 1'b1});
    tick();
    pc_valid = 1'b0;
    chk("t4_no_req", 64'(imem_req), 64'd0);
    chk("t4_valid",  64'(if_valid), 64'd1);
    chk("t4_err",    64'(if_err),   64'd1);
    chk("t4_instr",  64'(if_instr), 64'd0);
    chk("t4_pc",     64'(if_pc),    64'h42);
    if_ready = 1'b1;
    drain("t4_drain", 5);

    // flush while holding a word: the word is discarded
    if_ready = 1'b0;
    tick();
    pc_in = 32'h0000_0046; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("hold_flush_pre", 64'(if_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("hold_flush_valid", 64'(if_valid), 64'd0);
    #1 chk("hold_flush_idle", 64'(pc_ready), 64'd1);

    // T5: memory never answers -> timeout after TIMEOUT wait cycles
    mem_en = 1'b0;
    tick();
    pc_in = 32'h0000_0300; pc_valid = 1'b1;
    sb.push_back('{instr: 32'h0000_0000, pc: 32'h0000_0300, err: 1'b1});
    tick();
    pc_valid = 1'b0;
    n = 0;
    while (!if_valid && n < 300) begin
      if (imem_req) n++;
      tick();
    end
    chk("t5_wait_cycles", 64'(n), 64'(TIMEOUT));
    chk("t5_err",         64'(if_err),   64'd1);
    chk("t5_req_drop",    64'(imem_req), 64'd0);
    if_ready = 1'b1;
    drain("t5_drain", 5);

    // reset while a request is outstanding clears outputs asynchronously
    tick();
    pc_in = 32'h0000_0400; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("t5_mid_wait_req", 64'(imem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_arst_req",   64'(imem_req),  64'd0);
    chk("t5_arst_addr",  64'(imem_addr), 64'd0);
    chk("t5_arst_valid", 64'(if_valid),  64'd0);
    chk("t5_arst_err",   64'(if_err),    64'd0);
    tick();
    reset  = 1'b0;
    mem_en = 1'b1;

    // an acknowledge outside WAIT is ignored
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    chk("stray_ack_valid", 64'(if_valid), 64'd0);
    chk("stray_ack_req",   64'(imem_req), 64'd0);
    #1 chk("stray_ack_idle", 64'(pc_ready), 64'd1);

`ifdef FETCH_PERF_CNT_EN
    // T6: four fetches with three wait cycles each
    mem_lat  = 2;
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      pc_in = 32'h0000_0500 + 32'(4 * i); pc_valid = 1'b1;
      sb.push_back('{instr: mem_word(32'h0000_0500 + 32'(4 * i)),
                     pc: 32'h0000_0500 + 32'(4 * i), err: 1'b0});
      tick();
      pc_valid = 1'b0;
      drain("t6_drain", 10);
    end
    tick();
    chk("t6_perf_fetch", 64'(perf_fetch_cnt), 64'd4);
    chk("t6_perf_wait",  64'(perf_wait_cnt),  64'd12);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
